// File: rtl/switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : switch_allocator
//  Description : Packet-level switch allocator for a 4x4 router crossbar.
//                One round-robin arbiter per output; a grant is held until
//                the owning packet's tail flit transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_allocator #(
  parameter int NPORT = 4
) (
  input  logic             clk,
  input  logic             rst_n,      // active-high synchronous reset
  input  logic [NPORT-1:0] req0,
  input  logic [NPORT-1:0] req1,
  input  logic [NPORT-1:0] req2,
  input  logic [NPORT-1:0] req3,
  input  logic [NPORT-1:0] tail,
  input  logic [NPORT-1:0] out_ready,
  output logic [NPORT-1:0] sel0,
  output logic [NPORT-1:0] sel1,
  output logic [NPORT-1:0] sel2,
  output logic [NPORT-1:0] sel3,
  output logic [NPORT-1:0] busy,
  output logic [NPORT-1:0] gnt_in
);

  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Per-output arbiter state
  state_t           state   [NPORT];
  logic [IW-1:0]    owner   [NPORT];
  logic [IW-1:0]    ptr     [NPORT];
  logic [NPORT-1:0] sel_q   [NPORT];

  // Combinational helpers
  logic [NPORT-1:0] req_arr [NPORT];
  logic [NPORT-1:0] nreq    [NPORT];
  logic [NPORT-1:0] owns;
  logic [NPORT-1:0] win_valid;
  logic [IW-1:0]    win_idx [NPORT];
  logic [NPORT-1:0] claimed;
  logic [NPORT-1:0] xfer;
  logic [NPORT-1:0] gnt;

  assign req_arr[0] = req0;
  assign req_arr[1] = req1;
  assign req_arr[2] = req2;
  assign req_arr[3] = req3;

  // Keep only the lowest set bit of each request (two's-complement isolation)
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      nreq[i] = req_arr[i] & (~req_arr[i] + NPORT'(1));
    end
  end

  // Mark inputs that already own a locked output; they may not win another
  always_comb begin
    owns = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (state[j] == LOCKED) owns[owner[j]] = 1'b1;
    end
  end

  // Round-robin search per idle output; lower output index wins an input tie
  always_comb begin
    logic [IW-1:0] cidx;
    claimed = '0;
    cidx    = '0;
    for (int j = 0; j < NPORT; j++) begin
      win_valid[j] = 1'b0;
      win_idx[j]   = '0;
      if (state[j] == IDLE) begin
        for (int k = 1; k <= NPORT; k++) begin
          cidx = IW'((int'(ptr[j]) + k) % NPORT);
          if (!win_valid[j] && nreq[cidx][j] && !owns[cidx]) begin
            win_valid[j] = 1'b1;
            win_idx[j]   = cidx;
          end
        end
        // A first candidate already taken by a lower output means no grant
        // this cycle; this output retries on the next one.
        if (win_valid[j] && claimed[win_idx[j]]) win_valid[j] = 1'b0;
        if (win_valid[j]) claimed[win_idx[j]] = 1'b1;
      end
    end
  end

  // Flit transfer on each locked output and the per-input grant back to buffers
  always_comb begin
    xfer = '0;
    gnt  = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (!rst_n && state[j] == LOCKED) begin
        xfer[j] = nreq[owner[j]][j] & out_ready[j];
        if (xfer[j]) gnt[owner[j]] = 1'b1;
      end
    end
  end

  // Per-output IDLE/LOCKED state machine with registered sel and busy
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < NPORT; j++) begin
        state[j] <= IDLE;
        owner[j] <= '0;
        ptr[j]   <= IW'(NPORT - 1);
        sel_q[j] <= '0;
        busy[j]  <= 1'b0;
      end
    end else begin
      for (int j = 0; j < NPORT; j++) begin
        case (state[j])
          IDLE: begin
            if (win_valid[j]) begin
              state[j] <= LOCKED;
              owner[j] <= win_idx[j];
              ptr[j]   <= win_idx[j];
              sel_q[j] <= NPORT'(1) << win_idx[j];
              busy[j]  <= 1'b1;
            end
          end
          LOCKED: begin
            if (xfer[j] && tail[owner[j]]) begin
              state[j] <= IDLE;
              sel_q[j] <= '0;
              busy[j]  <= 1'b0;
            end
          end
          default: begin
            state[j] <= IDLE;
            sel_q[j] <= '0;
            busy[j]  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel0   = sel_q[0];
  assign sel1   = sel_q[1];
  assign sel2   = sel_q[2];
  assign sel3   = sel_q[3];
  assign gnt_in = gnt;

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_allocator
//  Description : Self-checking bench for switch_allocator: directed scenarios
//                with literal expectations plus randomized traffic compared
//                against a packet-level reference model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_allocator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req0, req1, req2, req3, tail, out_ready;
  logic [3:0] sel0, sel1, sel2, sel3, busy, gnt_in;

  int tests = 0;
  int fails = 0;

  // Reference model: which outputs are held, by whom, and each rotation point
  bit m_locked [4];
  int m_owner  [4];
  int m_ptr    [4];

  switch_allocator #(.NPORT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .req2      (req2),
    .req3      (req3),
    .tail      (tail),
    .out_ready (out_ready),
    .sel0      (sel0),
    .sel1      (sel1),
    .sel2      (sel2),
    .sel3      (sel3),
    .busy      (busy),
    .gnt_in    (gnt_in)
  );

  always #5 clk = ~clk;

  // Output an input wants: its lowest requested port, or -1 when idle
  function automatic int lowest(logic [3:0] r);
    for (int b = 0; b < 4; b++) if (r[b]) return b;
    return -1;
  endfunction

  task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d);
    req0 = a; req1 = b; req2 = c; req3 = d;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b1;
    set_req(4'b0, 4'b0, 4'b0, 4'b0);
    tick();
    rst_n = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < 4; j++) begin
      m_locked[j] = 1'b0;
      m_owner[j]  = 0;
      m_ptr[j]    = 3;
    end
  end

  // Every cycle: compare the DUT against the model, then advance the model
  always @(negedge clk) begin
    int         want [4];
    logic [3:0] rq [4];
    logic [3:0] sv [4];
    logic [3:0] exp_gnt, exp_busy, exp_sel, seen;
    bit         inv_ok, taken [4], claimed [4], nl [4];
    int         no [4], np [4], cand, i;
    string      nm;

    rq[0] = req0; rq[1] = req1; rq[2] = req2; rq[3] = req3;
    sv[0] = sel0; sv[1] = sel1; sv[2] = sel2; sv[3] = sel3;
    for (int k = 0; k < 4; k++) want[k] = lowest(rq[k]);

    exp_gnt  = 4'b0;
    exp_busy = 4'b0;
    for (int j = 0; j < 4; j++) begin
      exp_busy[j] = m_locked[j];
      if (!rst_n && m_locked[j] && want[m_owner[j]] == j && out_ready[j])
        exp_gnt[m_owner[j]] = 1'b1;
    end
    for (int j = 0; j < 4; j++) begin
      exp_sel = m_locked[j] ? (4'b0001 << m_owner[j]) : 4'b0000;
      nm = $sformatf("model sel%0d", j);
      chk(nm, sv[j], exp_sel);
    end
    chk("model busy", busy, exp_busy);
    chk("model gnt_in", gnt_in, exp_gnt);

    // Structural invariants checked directly on the DUT outputs
    inv_ok = 1'b1;
    seen   = 4'b0;
    for (int j = 0; j < 4; j++) begin
      if (!$onehot0(sv[j])) inv_ok = 1'b0;
      if ((seen & sv[j]) != 4'b0) inv_ok = 1'b0;
      seen = seen | sv[j];
    end
    if ((gnt_in & ~seen) != 4'b0) inv_ok = 1'b0;
    tests++;
    if (!inv_ok) begin
      fails++;
      $display("FAIL invariants: sel=%b/%b/%b/%b gnt_in=%b at %0t",
               sel0, sel1, sel2, sel3, gnt_in, $time);
    end

    // Advance the model across the coming posedge
    if (rst_n) begin
      for (int j = 0; j < 4; j++) begin
        m_locked[j] = 1'b0;
        m_ptr[j]    = 3;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        taken[k]   = 1'b0;
        claimed[k] = 1'b0;
      end
      for (int j = 0; j < 4; j++) if (m_locked[j]) taken[m_owner[j]] = 1'b1;
      for (int j = 0; j < 4; j++) begin
        nl[j] = m_locked[j];
        no[j] = m_owner[j];
        np[j] = m_ptr[j];
        if (m_locked[j]) begin
          if (want[m_owner[j]] == j && out_ready[j] && tail[m_owner[j]]) nl[j] = 1'b0;
        end else begin
          cand = -1;
          for (int k = 1; k <= 4; k++) begin
            i = (m_ptr[j] + k) % 4;
            if (cand < 0 && want[i] == j && !taken[i]) cand = i;
          end
          if (cand >= 0 && !claimed[cand]) begin
            nl[j] = 1'b1;
            no[j] = cand;
            np[j] = cand;
            claimed[cand] = 1'b1;
          end
        end
      end
      for (int j = 0; j < 4; j++) begin
        m_locked[j] = nl[j];
        m_owner[j]  = no[j];
        m_ptr[j]    = np[j];
      end
    end
  end

  // Directed scenarios with literal expectations, then randomized traffic
  initial begin
    logic [3:0] fair_seq [9];

    fair_seq[0] = 4'b0001; fair_seq[1] = 4'b0000; fair_seq[2] = 4'b0010;
    fair_seq[3] = 4'b0000; fair_seq[4] = 4'b0100; fair_seq[5] = 4'b0000;
    fair_seq[6] = 4'b1000; fair_seq[7] = 4'b0000; fair_seq[8] = 4'b0001;

    // Reset held two cycles while everything requests
    rst_n = 1'b1;
    set_req(4'b1111, 4'b1111, 4'b1111, 4'b1111);
    tail = 4'b1111;
    out_ready = 4'b1111;
    tick();
    tick();
    @(negedge clk);
    chk("reset sel0", sel0, 4'b0000);
    chk("reset sel3", sel3, 4'b0000);
    chk("reset busy", busy, 4'b0000);
    chk("reset gnt_in", gnt_in, 4'b0000);

    // No conflict: every input to a distinct output, single-flit packets
    do_reset();
    set_req(4'b0001, 4'b0010, 4'b0100, 4'b1000);
    tail = 4'b1111;
    out_ready = 4'b1111;
    tick();
    @(negedge clk);
    chk("noconf sel0", sel0, 4'b0001);
    chk("noconf sel1", sel1, 4'b0010);
    chk("noconf sel2", sel2, 4'b0100);
    chk("noconf sel3", sel3, 4'b1000);
    chk("noconf gnt_in", gnt_in, 4'b1111);
    tick();
    set_req(4'b0, 4'b0, 4'b0, 4'b0);
    @(negedge clk);
    chk("noconf after busy", busy, 4'b0000);

    // Fairness on output 0
    do_reset();
    set_req(4'b0001, 4'b0001, 4'b0001, 4'b0001);
    tail = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("fair sel0[%0d]", k), sel0, fair_seq[k]);
    end

    // Packet hold: input 1 sends four flits, input 3 waits
    do_reset();
    set_req(4'b0000, 4'b0010, 4'b0000, 4'b0010);
    tail = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      tail = (k == 3) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      chk($sformatf("hold sel1[%0d]", k), sel1, 4'b0010);
      chk($sformatf("hold gnt_in[%0d]", k), gnt_in & 4'b0010, 4'b0010);
    end
    tick();
    tail = 4'b0000;
    set_req(4'b0000, 4'b0000, 4'b0000, 4'b0010);
    @(negedge clk);
    chk("hold gap sel1", sel1, 4'b0000);
    tick();
    @(negedge clk);
    chk("hold next sel1", sel1, 4'b1000);

    // Backpressure on output 2
    do_reset();
    set_req(4'b0100, 4'b0000, 4'b0000, 4'b0000);
    tail = 4'b0000;
    out_ready = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("bp sel2[%0d]", k), sel2, 4'b0001);
      chk($sformatf("bp gnt_in[%0d]", k), gnt_in, 4'b0000);
    end
    tick();
    out_ready = 4'b1111;
    @(negedge clk);
    chk("bp release gnt_in", gnt_in, 4'b0001);
    chk("bp release sel2", sel2, 4'b0001);

    // Reset mid-packet
    do_reset();
    set_req(4'b0000, 4'b0000, 4'b0000, 4'b0010);
    tail = 4'b0000;
    tick();
    @(negedge clk);
    chk("midrst locked sel1", sel1, 4'b1000);
    tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    set_req(4'b0010, 4'b0000, 4'b0000, 4'b0010);
    @(negedge clk);
    chk("midrst after sel1", sel1, 4'b0000);
    tick();
    @(negedge clk);
    chk("midrst regrant sel1", sel1, 4'b0001);

    // Randomized traffic, checked by the model process
    for (int n = 0; n < 1500; n++) begin
      logic [3:0] rr [4];
      tick();
      rst_n = ($urandom_range(0, 99) == 0);
      for (int k = 0; k < 4; k++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 3)      rr[k] = 4'b0000;
        else if (r < 8) rr[k] = 4'b0001 << $urandom_range(0, 3);
        else            rr[k] = 4'($urandom_range(0, 15));
        tail[k]      = ($urandom_range(0, 2) == 0);
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
      set_req(rr[0], rr[1], rr[2], rr[3]);
    end

    tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
